// File: rtl/operand_tf_pkg.sv
// ============================================================================
// Module  : operand_tf_pkg
// Brief   : Shared widths and state encoding for the operand transformer path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_tf_pkg;

  localparam int ELEM_W  = 8;
  localparam int SCALE_W = 8;

  typedef enum logic [1:0] {
    BS_COLLECT = 2'd0,
    BS_SCALE   = 2'd1,
    BS_EMIT    = 2'd2
  } bs_state_e;

endpackage

`default_nettype wire

// File: rtl/leading_one_detector.sv
// ============================================================================
// Module  : leading_one_detector
// Brief   : Combinational priority encoder returning the highest set bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module leading_one_detector #(
  parameter int W = 16
) (
  input  logic [W-1:0]         data,
  output logic [$clog2(W)-1:0] pos,
  output logic                 is_zero
);

  localparam int c_pos_w = $clog2(W);

  // Ascending scan: the last hit wins, which is the most significant one.
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (data[i]) begin
        pos = c_pos_w'(i);
      end
    end
  end

  assign is_zero = (data == '0);

endmodule

`default_nettype wire

// File: rtl/block_scale_encoder.sv
// ============================================================================
// Module  : block_scale_encoder
// Brief   : Collects a block of wide values, derives one shared scale and emits
//           8-bit elements such that element << scale approximates each value.
//           Optional OPERAND_TF_ROUND_EN selects round-half-up with saturation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module block_scale_encoder
  import operand_tf_pkg::*;
#(
  parameter int WIDE_W     = 16,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDE_W-1:0]             in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ELEM_W-1:0]             out_element,
  output logic [SCALE_W-1:0]            out_scale,
  output logic [$clog2(BLOCK_SIZE)-1:0] out_index,
  output logic                          out_last
);

  localparam int c_idx_w = $clog2(BLOCK_SIZE);
  localparam int c_cnt_w = $clog2(BLOCK_SIZE + 1);
  localparam int c_pos_w = $clog2(WIDE_W);

  bs_state_e           r_state;
  bs_state_e           w_state_nxt;
  logic [WIDE_W-1:0]   r_buf [BLOCK_SIZE];
  logic [c_cnt_w-1:0]  r_count;
  logic [c_idx_w-1:0]  r_index;
  logic [c_pos_w-1:0]  r_max_pos;
  logic [SCALE_W-1:0]  r_scale;

  logic [c_pos_w-1:0]  w_lod_pos;
  logic                w_lod_zero;
  logic                w_accept;
  logic                w_block_done;
  logic                w_emit_hs;
  logic                w_is_last;
  logic [WIDE_W-1:0]   w_word;
  logic [ELEM_W-1:0]   w_trunc;
  logic [ELEM_W-1:0]   w_elem;

  leading_one_detector #(
    .W (WIDE_W)
  ) u_lod (
    .data    (in_data),
    .pos     (w_lod_pos),
    .is_zero (w_lod_zero)
  );

  // Handshakes decoded from the state register to keep the FSM outputs loop-free.
  assign w_accept     = in_valid && (r_state == BS_COLLECT);
  assign w_block_done = w_accept && (in_last || (r_count == c_cnt_w'(BLOCK_SIZE - 1)));
  assign w_emit_hs    = out_ready && (r_state == BS_EMIT);
  assign w_is_last    = (c_cnt_w'(r_index) == (r_count - c_cnt_w'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BS_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      BS_COLLECT: begin
        in_ready = 1'b1;
        if (w_block_done) begin
          w_state_nxt = BS_SCALE;
        end
      end
      BS_SCALE: begin
        w_state_nxt = BS_EMIT;
      end
      BS_EMIT: begin
        out_valid = 1'b1;
        if (out_ready && w_is_last) begin
          w_state_nxt = BS_COLLECT;
        end
      end
      default: begin
        w_state_nxt = BS_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_index   <= '0;
      r_max_pos <= '0;
      r_scale   <= '0;
    end else begin
      case (r_state)
        BS_COLLECT: begin
          if (w_accept) begin
            r_count <= r_count + c_cnt_w'(1);
            if (!w_lod_zero && (w_lod_pos > r_max_pos)) begin
              r_max_pos <= w_lod_pos;
            end
          end
        end
        BS_SCALE: begin
          r_scale <= (r_max_pos > c_pos_w'(7)) ? (SCALE_W'(r_max_pos) - SCALE_W'(7)) : '0;
        end
        BS_EMIT: begin
          if (w_emit_hs) begin
            if (w_is_last) begin
              r_count   <= '0;
              r_index   <= '0;
              r_max_pos <= '0;
            end else begin
              r_index <= r_index + c_idx_w'(1);
            end
          end
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

  // Payload storage carries no reset; stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_count[c_idx_w-1:0]] <= in_data;
    end
  end

  assign w_word  = r_buf[r_index];
  assign w_trunc = ELEM_W'(w_word >> r_scale);

`ifdef OPERAND_TF_ROUND_EN
  logic              w_round_bit;
  logic [ELEM_W:0]   w_sum;

  assign w_round_bit = (r_scale != '0) && 1'(w_word >> (r_scale - SCALE_W'(1)));
  assign w_sum       = {1'b0, w_trunc} + (ELEM_W + 1)'(w_round_bit);
  assign w_elem      = w_sum[ELEM_W] ? '1 : w_sum[ELEM_W-1:0];
`else
  assign w_elem      = w_trunc;
`endif

  assign out_element = (r_state == BS_EMIT) ? w_elem : '0;
  assign out_scale   = r_scale;
  assign out_index   = r_index;
  assign out_last    = (r_state == BS_EMIT) && w_is_last;

endmodule

`default_nettype wire

// File: tb/tb_block_scale_encoder.sv
// ============================================================================
// Module  : tb_block_scale_encoder
// Brief   : Self-checking bench for block_scale_encoder against a value-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_scale_encoder;

  localparam int WIDE_W = 16;
  localparam int BS     = 8;
  localparam int IDX_W  = $clog2(BS);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDE_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_element;
  logic [7:0]        out_scale;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDE_W-1:0] vals [BS];
  logic [7:0]        exp_elem [BS];
  logic [7:0]        exp_scale;

  block_scale_encoder #(
    .WIDE_W     (WIDE_W),
    .BLOCK_SIZE (BS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_element (out_element),
    .out_scale   (out_scale),
    .out_index   (out_index),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  // Reference: scale from the magnitude of the largest value, element by plain division.
  function automatic int lead_pos(input logic [WIDE_W-1:0] v);
    if (v == '0) return -1;
    return $clog2(longint'(v) + 1) - 1;
  endfunction

  task automatic compute_expected(input int n);
    int mx = -1;
    int s;
    longint e;
    for (int i = 0; i < n; i++) begin
      if (lead_pos(vals[i]) > mx) mx = lead_pos(vals[i]);
    end
    s = (mx > 7) ? mx - 7 : 0;
    exp_scale = 8'(s);
    for (int i = 0; i < n; i++) begin
      e = longint'(vals[i]) / (longint'(1) << s);
`ifdef OPERAND_TF_ROUND_EN
      if (s > 0) e = e + ((longint'(vals[i]) / (longint'(1) << (s - 1))) % 2);
      if (e > 255) e = 255;
`endif
      exp_elem[i] = e[7:0];
    end
  endtask

  task automatic send_block(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vals[i];
      in_last  = use_last && (i == n - 1);
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL in_ready_collect: got %b want 1 (value %0d)", in_ready, i);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL scale_cycle: out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
    end
  endtask

  // Drains n elements with random stalls; stop_at >= 0 leaves the block while that index is shown.
  task automatic recv_block(input int n, input int stall_pct, input int stop_at);
    int got  = 0;
    int cyc  = 0;
    bit seen = 1'b0;
    bit hs;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(99) >= stall_pct);
      if (cyc == 1) begin
        n_tests++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL first_valid_latency: out_valid=%b want 1", out_valid);
        end
      end
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        n_tests++;
        if (out_element !== exp_elem[got] || out_index !== IDX_W'(got) ||
            out_scale !== exp_scale || out_last !== (got == n - 1) || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL emit_elem%0d: elem=%h idx=%0d scale=%0d last=%b in_ready=%b want elem=%h idx=%0d scale=%0d last=%b in_ready=0",
                   got, out_element, out_index, out_scale, out_last, in_ready,
                   exp_elem[got], got, exp_scale, (got == n - 1));
        end
        if (stop_at >= 0 && got == stop_at) begin
          out_ready = 1'b0;
          return;
        end
      end else if (seen) begin
        n_tests++;
        n_fail++;
        $display("FAIL valid_dropped: out_valid=0 before element %0d, want 1", got);
      end
      hs = (out_valid === 1'b1) && out_ready;
      if (hs) got++;
    end
    n_tests++;
    if (got < n) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d elements want %0d", got, n);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL return_collect: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic run_block(input int n, input bit use_last, input int stall_pct);
    compute_expected(n);
    send_block(n, use_last);
    recv_block(n, stall_pct, -1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_element !== 8'h00 || out_scale !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b last=%b elem=%h scale=%h want 1/0/0/00/00",
               in_ready, out_valid, out_last, out_element, out_scale);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_incrementing;
    for (int i = 0; i < BS; i++) vals[i] = WIDE_W'(i + 1);
    run_block(BS, 1'b0, 0);
  endtask

  task automatic test_mixed;
    vals[0] = 16'h1234;
    for (int i = 1; i < BS; i++) vals[i] = 16'h0001;
    run_block(BS, 1'b0, 0);
  endtask

  task automatic test_saturate;
    for (int i = 0; i < BS; i++) vals[i] = 16'hFFFF;
    run_block(BS, 1'b1, 0);
  endtask

  task automatic test_short_zero;
    for (int i = 0; i < 3; i++) vals[i] = '0;
    run_block(3, 1'b1, 0);
  endtask

  task automatic test_one_element;
    vals[0] = 16'h0ABC;
    run_block(1, 1'b1, 20);
  endtask

  task automatic test_backpressure;
    vals[0] = 16'h1234;
    for (int i = 1; i < BS; i++) vals[i] = 16'h0001;
    run_block(BS, 1'b0, 50);
  endtask

  task automatic test_random;
    int n;
    bit use_last;
    logic [WIDE_W-1:0] mask;
    for (int b = 0; b < 20; b++) begin
      n        = $urandom_range(BS, 1);
      use_last = (n < BS) ? 1'b1 : 1'($urandom_range(1));
      mask     = WIDE_W'((32'd1 << $urandom_range(WIDE_W)) - 1);
      for (int i = 0; i < n; i++) vals[i] = WIDE_W'($urandom) & mask;
      run_block(n, use_last, 30);
    end
  endtask

  task automatic test_reset_mid_emit;
    vals[0] = 16'hF00D;
    for (int i = 1; i < BS; i++) vals[i] = WIDE_W'(i * 300);
    compute_expected(BS);
    send_block(BS, 1'b0);
    recv_block(BS, 0, 3);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || out_scale !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b last=%b scale=%h want 0/1/0/00",
               out_valid, in_ready, out_last, out_scale);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < BS; i++) vals[i] = WIDE_W'($urandom_range(255));
    run_block(BS, 1'b0, 0);
  endtask

  initial begin
    test_reset;
    test_incrementing;
    test_mixed;
    test_saturate;
    test_short_zero;
    test_one_element;
    test_backpressure;
    test_random;
    test_reset_mid_emit;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
